// File: rtl/cell_bist_pkg.sv
// Cell codes, FSM state encoding and the input-count helper shared by the
// cell BIST sequencer and its golden model.
`default_nettype none

package cell_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] CELL_AND2    = 4'd0;
  localparam logic [3:0] CELL_AND3    = 4'd1;
  localparam logic [3:0] CELL_AND4    = 4'd2;
  localparam logic [3:0] CELL_BUF     = 4'd3;
  localparam logic [3:0] CELL_INV     = 4'd4;
  localparam logic [3:0] CELL_NAND2   = 4'd5;
  localparam logic [3:0] CELL_NAND3   = 4'd6;
  localparam logic [3:0] CELL_NAND4   = 4'd7;
  localparam logic [3:0] CELL_NOR2    = 4'd8;
  localparam logic [3:0] CELL_NOR3    = 4'd9;
  localparam logic [3:0] CELL_NOR4    = 4'd10;
  localparam logic [3:0] CELL_OR2     = 4'd11;
  localparam logic [3:0] CELL_OR3     = 4'd12;
  localparam logic [3:0] CELL_OR4     = 4'd13;
  localparam logic [3:0] CELL_XNOR2   = 4'd14;
  localparam logic [3:0] CELL_ILLEGAL = 4'd15;

  // Number of cell inputs; 0 only for the illegal code.
  function automatic logic [2:0] cell_inputs(input logic [3:0] code);
    logic [2:0] n;
    n = 3'd0;
    case (code)
      CELL_BUF, CELL_INV:                                         n = 3'd1;
      CELL_AND2, CELL_NAND2, CELL_NOR2, CELL_OR2, CELL_XNOR2:     n = 3'd2;
      CELL_AND3, CELL_NAND3, CELL_NOR3, CELL_OR3:                 n = 3'd3;
      CELL_AND4, CELL_NAND4, CELL_NOR4, CELL_OR4:                 n = 3'd4;
      default:                                                    n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cell_golden.sv
// Combinational golden model of every supported cell; pat[0] is A1/A,
// pat[1] is A2/B, pat[2] is A3, pat[3] is A4.
`default_nettype none

module cell_golden
  import cell_bist_pkg::*;
(
  input  logic [3:0] code,
  input  logic [3:0] pat,
  output logic       exp
);

  always_comb begin
    exp = 1'b0;
    case (code)
      CELL_AND2:  exp = &pat[1:0];
      CELL_AND3:  exp = &pat[2:0];
      CELL_AND4:  exp = &pat[3:0];
      CELL_BUF:   exp = pat[0];
      CELL_INV:   exp = ~pat[0];
      CELL_NAND2: exp = ~(&pat[1:0]);
      CELL_NAND3: exp = ~(&pat[2:0]);
      CELL_NAND4: exp = ~(&pat[3:0]);
      CELL_NOR2:  exp = ~(|pat[1:0]);
      CELL_NOR3:  exp = ~(|pat[2:0]);
      CELL_NOR4:  exp = ~(|pat[3:0]);
      CELL_OR2:   exp = |pat[1:0];
      CELL_OR3:   exp = |pat[2:0];
      CELL_OR4:   exp = |pat[3:0];
      CELL_XNOR2: exp = ~(pat[0] ^ pat[1]);
      default:    exp = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cell_bist_ctrl.sv
// BIST sequencer: walks every input vector of the selected cell, holds each
// for SETTLE+1 cycles, compares RESP to the golden model and counts mismatches.
`default_nettype none

module cell_bist_ctrl
  import cell_bist_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 5
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic [3:0]       CELL_SEL,
  input  logic             RESP,
  output logic [3:0]       PAT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [3:0]       SETTLE_VAL = SETTLE[3:0];
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t           state, state_n;
  logic [3:0]       code, code_n;
  logic [3:0]       pat, pat_n;
  logic [3:0]       hold, hold_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             pass, pass_n;
  logic [ERR_W-1:0] err, err_n;
  logic [ERR_W-1:0] err_sum;
  logic [4:0]       span;
  logic [4:0]       last_full;
  logic             exp;

  cell_golden u_golden (
    .code (code),
    .pat  (pat),
    .exp  (exp)
  );

  always_ff @(posedge CK) begin
    if (!RN) begin
      state <= ST_IDLE;
      code  <= 4'd0;
      pat   <= 4'd0;
      hold  <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      err   <= '0;
    end else begin
      state <= state_n;
      code  <= code_n;
      pat   <= pat_n;
      hold  <= hold_n;
      busy  <= busy_n;
      done  <= done_n;
      pass  <= pass_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    code_n    = code;
    pat_n     = pat;
    hold_n    = hold;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;
    err_n     = err;
    err_sum   = err;
    span      = 5'd1 << cell_inputs(code);
    last_full = span - 5'd1;

    case (state)
      ST_RUN: begin
        if (hold != 4'd0) begin
          hold_n = hold - 4'd1;
        end else begin
          // Final-vector mismatch must land in the count used for PASS.
          if ((RESP != exp) && (err != ERR_MAX)) begin
            err_sum = err + 1'b1;
          end
          err_n = err_sum;
          if (pat == last_full[3:0]) begin
            state_n = ST_FIN;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_sum == '0);
            pat_n   = 4'd0;
          end else begin
            pat_n  = pat + 4'd1;
            hold_n = SETTLE_VAL;
          end
        end
      end
      default: begin
        if (START) begin
          code_n = CELL_SEL;
          pat_n  = 4'd0;
          err_n  = '0;
          pass_n = 1'b0;
          if (CELL_SEL == CELL_ILLEGAL) begin
            state_n = ST_FIN;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = ST_RUN;
            hold_n  = SETTLE_VAL;
            busy_n  = 1'b1;
            done_n  = 1'b0;
          end
        end
      end
    endcase
  end

  assign PAT     = pat;
  assign BUSY    = busy;
  assign DONE    = done;
  assign PASS    = pass;
  assign ERR_CNT = err;

endmodule

`default_nettype wire

// File: tb/tb_cell_bist_ctrl.sv
// Self-checking bench for cell_bist_ctrl: table-driven runs with a PAT
// scoreboard, plus hand sequences for illegal code, START-while-busy and reset.
`default_nettype none

module tb_cell_bist_ctrl;

  typedef struct {
    logic [3:0] code;
    bit         stuck;
    bit         exp_pass;
    int         exp_err5;
    int         exp_err3;
  } vec_t;

  logic       ck, rn, start, resp;
  logic [3:0] cell_sel;
  logic [3:0] pat, pat3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [4:0] err5;
  logic [2:0] err3;

  logic [3:0] h_code;
  bit         h_stuck;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int ntab[16] = '{2, 3, 4, 1, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 2, 0};
  vec_t tbl[7];

  cell_bist_ctrl #(.SETTLE(1), .ERR_W(5)) dut (
    .CK(ck), .RN(rn), .START(start), .CELL_SEL(cell_sel), .RESP(resp),
    .PAT(pat), .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err5)
  );

  cell_bist_ctrl #(.SETTLE(1), .ERR_W(3)) dut3 (
    .CK(ck), .RN(rn), .START(start), .CELL_SEL(cell_sel), .RESP(resp),
    .PAT(pat3), .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Behavioural cell under test, written as mask tests on the active inputs.
  function automatic logic model(input logic [3:0] c, input logic [3:0] p);
    logic [4:0] t;
    logic [3:0] m, a;
    t = 5'd1 << ntab[c];
    t = t - 5'd1;
    m = t[3:0];
    a = p & m;
    case (c)
      4'd0, 4'd1, 4'd2:    return (a == m);
      4'd5, 4'd6, 4'd7:    return (a != m);
      4'd8, 4'd9, 4'd10:   return (a == 4'd0);
      4'd11, 4'd12, 4'd13: return (a != 4'd0);
      4'd3:                return p[0];
      4'd4:                return ~p[0];
      4'd14:               return (p[0] == p[1]);
      default:             return 1'b0;
    endcase
  endfunction

  assign resp = h_stuck ? 1'b0 : model(h_code, pat);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_idle_reset();
    chk("rst_pat", pat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err5", err5, 0);
    chk("rst_err3", err3, 0);
  endtask

  // glitch >= 0: pulse START with CELL_SEL=0 at that cycle of the run.
  task automatic do_run(input vec_t v, input int glitch);
    int nv, len, e;
    nv = 1 << ntab[v.code];
    @(negedge ck);
    h_code   = v.code;
    h_stuck  = v.stuck;
    cell_sel = v.code;
    start    = 1'b1;
    for (int p = 0; p < nv; p++) begin
      exp_q.push_back(p);
      exp_q.push_back(p);
    end
    len = exp_q.size();
    @(posedge ck); #1;
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == glitch) begin
        start = 1'b1;
        cell_sel = 4'd0;
      end else if (i == glitch + 1) begin
        start = 1'b0;
      end
      e = exp_q.pop_front();
      chk("run_pat", pat, e);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      @(posedge ck); #1;
    end
    start = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_pat", pat, 0);
    chk("end_pass", pass, v.exp_pass);
    chk("end_err5", err5, v.exp_err5);
    chk("end_err3", err3, v.exp_err3);
    chk("end_pass3", pass3, v.exp_pass);
  endtask

  initial begin
    tbl[0] = '{code: 4'd0,  stuck: 0, exp_pass: 1, exp_err5: 0,  exp_err3: 0};
    tbl[1] = '{code: 4'd7,  stuck: 1, exp_pass: 0, exp_err5: 15, exp_err3: 7};
    tbl[2] = '{code: 4'd14, stuck: 0, exp_pass: 1, exp_err5: 0,  exp_err3: 0};
    tbl[3] = '{code: 4'd4,  stuck: 1, exp_pass: 0, exp_err5: 1,  exp_err3: 1};
    tbl[4] = '{code: 4'd2,  stuck: 1, exp_pass: 0, exp_err5: 1,  exp_err3: 1};
    tbl[5] = '{code: 4'd3,  stuck: 0, exp_pass: 1, exp_err5: 0,  exp_err3: 0};
    tbl[6] = '{code: 4'd10, stuck: 0, exp_pass: 1, exp_err5: 0,  exp_err3: 0};

    rn = 1'b0; start = 1'b0; cell_sel = 4'd0; h_code = 4'd0; h_stuck = 0;
    repeat (3) @(posedge ck);
    #1;
    chk_idle_reset();
    @(negedge ck);
    rn = 1'b1;
    @(posedge ck); #1;

    for (int i = 0; i < 7; i++) begin
      do_run(tbl[i], -1);
      if (i == 1) begin
        // Illegal code straight from FIN after a failing run.
        @(negedge ck);
        cell_sel = 4'd15;
        start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        chk("ill_done", done, 1);
        chk("ill_pass", pass, 0);
        chk("ill_busy", busy, 0);
        chk("ill_pat", pat, 0);
        chk("ill_err5", err5, 0);
        repeat (2) begin
          @(posedge ck); #1;
          chk("ill_hold_busy", busy, 0);
          chk("ill_hold_done", done, 1);
        end
      end
    end

    // START and CELL_SEL change during an OR3 run are ignored.
    do_run('{code: 4'd12, stuck: 0, exp_pass: 1, exp_err5: 0, exp_err3: 0}, 6);

    // Reset in the middle of an INV run.
    @(negedge ck);
    h_code = 4'd4; h_stuck = 0; cell_sel = 4'd4; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    chk("mid_pat", pat, 1);
    chk("mid_busy", busy, 1);
    rn = 1'b0;
    @(posedge ck); #1;
    chk_idle_reset();
    rn = 1'b1;
    @(posedge ck); #1;
    chk("post_rst_busy", busy, 0);
    do_run('{code: 4'd4, stuck: 0, exp_pass: 1, exp_err5: 0, exp_err3: 0}, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
